// File: rtl/fft_peak_analyzer_if.sv
// Frame input and peak-result bus between the 16-point FFT and the peak analyzer.
interface fft_peak_analyzer_if #(
  parameter int NBIN = 16,
  parameter int DW   = 16
);
  logic                    fft_valid;
  logic [NBIN*2*DW-1:0]    fft_data;
  logic                    busy;
  logic                    done;
  logic [$clog2(NBIN)-1:0] freq;
  logic                    overrun;

  modport master (
    output fft_valid, fft_data,
    input  busy, done, freq, overrun
  );

  modport slave (
    input  fft_valid, fft_data,
    output busy, done, freq, overrun
  );
endinterface

// File: rtl/fft_peak_analyzer.sv
// Scans a captured FFT frame one bin per cycle and reports the strongest bin index,
// with a one-frame pending buffer so frames arriving mid-scan are not lost.
module fft_peak_analyzer #(
  parameter int NBIN       = 16,
  parameter int DW         = 16,
  parameter int DC_EXCLUDE = 1
) (
  input  logic              clk,
  input  logic              rst,
  fft_peak_analyzer_if.slave bus
);
  localparam int FW = NBIN * 2 * DW;
  localparam int BW = 2 * DW;
  localparam int CW = $clog2(NBIN);
  localparam logic [CW-1:0] FIRST = CW'((DC_EXCLUDE != 0) ? 1 : 0);
  localparam logic [CW-1:0] LAST  = CW'(NBIN - 1);

  typedef enum logic {IDLE, SCAN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] act_q, act_d;
  logic [FW-1:0] pend_q, pend_d;
  logic          pv_q, pv_d;
  logic [BW-1:0] max_q, max_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] freq_q, freq_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;

  logic [BW-1:0]        bin_w;
  logic signed [DW-1:0] re_w, im_w;
  logic signed [BW-1:0] sq_re_w, sq_im_w;
  logic [BW-1:0]        mag_w;
  logic                 skip_w, first_w, upd_w, last_w;

  // Squares are at most 2^30 each, so the unsigned 32-bit sum cannot wrap.
  always_comb begin
    bin_w   = act_q[cnt_q * BW +: BW];
    re_w    = bin_w[BW-1:DW];
    im_w    = bin_w[DW-1:0];
    sq_re_w = re_w * re_w;
    sq_im_w = im_w * im_w;
    mag_w   = $unsigned(sq_re_w) + $unsigned(sq_im_w);
    skip_w  = (DC_EXCLUDE != 0) && (cnt_q == '0);
    first_w = (cnt_q == FIRST);
    upd_w   = !skip_w && (first_w || (mag_w > max_q));
    last_w  = (cnt_q == LAST);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    pend_d  = pend_q;
    pv_d    = pv_q;
    max_d   = max_q;
    idx_d   = idx_q;
    freq_d  = freq_q;
    done_d  = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.fft_valid) begin
          act_d   = bus.fft_data;
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (upd_w) begin
          max_d = mag_w;
          idx_d = cnt_q;
        end
        cnt_d = cnt_q + 1'b1;
        if (last_w) begin
          freq_d = upd_w ? cnt_q : idx_q;
          done_d = 1'b1;
          if (pv_q) begin
            // Handover edge: pending slot frees up, so a new frame is accepted.
            act_d = pend_q;
            cnt_d = '0;
            pv_d  = 1'b0;
            if (bus.fft_valid) begin
              pend_d = bus.fft_data;
              pv_d   = 1'b1;
            end
          end else if (bus.fft_valid) begin
            act_d = bus.fft_data;
            cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (bus.fft_valid) begin
          if (!pv_q) begin
            pend_d = bus.fft_data;
            pv_d   = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      act_q   <= '0;
      pend_q  <= '0;
      pv_q    <= 1'b0;
      max_q   <= '0;
      idx_q   <= '0;
      freq_q  <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      pv_q    <= pv_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      freq_q  <= freq_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.busy    = (state_q == SCAN);
  assign bus.done    = done_q;
  assign bus.freq    = freq_q;
  assign bus.overrun = ovr_q;
endmodule

// File: tb/tb_fft_peak_analyzer.sv
// Directed bench for fft_peak_analyzer; two instances cover both DC_EXCLUDE settings,
// with expected peak indices queued at send time and popped on each done pulse.
module tb_fft_peak_analyzer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         vld  = 1'b0;
  logic [511:0] data = '0;

  fft_peak_analyzer_if #(.NBIN(16), .DW(16)) if0 ();
  fft_peak_analyzer_if #(.NBIN(16), .DW(16)) if1 ();
  assign if0.fft_valid = vld;
  assign if0.fft_data  = data;
  assign if1.fft_valid = vld;
  assign if1.fft_data  = data;

  fft_peak_analyzer #(.NBIN(16), .DW(16), .DC_EXCLUDE(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  fft_peak_analyzer #(.NBIN(16), .DW(16), .DC_EXCLUDE(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  int n_cmp = 0, n_err = 0;
  logic [3:0] q0[$], q1[$];
  int dn0 = 0, dn1 = 0, last0 = 0, ovr0 = 0, gap = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] fr(input logic [31:0] fill, input int b1, input logic [31:0] v1,
                                      input int b2, input logic [31:0] v2);
    logic [511:0] f;
    for (int k = 0; k < 16; k++) f[k*32 +: 32] = fill;
    f[b1*32 +: 32] = v1;
    f[b2*32 +: 32] = v2;
    return f;
  endfunction

  function automatic logic [3:0] peak(input logic [511:0] f, input bit dcx);
    logic signed [15:0] re, im;
    longint m, best_m;
    int first, best;
    first  = dcx ? 1 : 0;
    best   = first;
    best_m = -1;
    for (int k = first; k < 16; k++) begin
      re = f[k*32+16 +: 16];
      im = f[k*32 +: 16];
      m  = longint'(re) * longint'(re) + longint'(im) * longint'(im);
      if (m > best_m) begin
        best_m = m;
        best   = k;
      end
    end
    return 4'(best);
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (if0.done) begin
        dn0++;
        last0 = cyc;
        if (q0.size() == 0) chk("sb0_unexpected_done", 64'(q0.size()), 1);
        else chk("sb0_freq", 64'(if0.freq), 64'(q0.pop_front()));
      end
      if (if1.done) begin
        dn1++;
        if (q1.size() == 0) chk("sb1_unexpected_done", 64'(q1.size()), 1);
        else chk("sb1_freq", 64'(if1.freq), 64'(q1.pop_front()));
      end
      if (if0.overrun) ovr0++;
      if (!if0.busy) gap++;
    end
  endtask

  task automatic send(input logic [511:0] f, input bit push);
    vld  = 1'b1;
    data = f;
    if (push) begin
      q0.push_back(peak(f, 1'b1));
      q1.push_back(peak(f, 1'b0));
    end
    tick(1);
    vld = 1'b0;
  endtask

  task automatic run_single(input string tag, input logic [511:0] f, input int exp0, input int exp1);
    int e0, db;
    db = dn0;
    send(f, 1'b1);
    e0 = cyc;
    tick(15);
    chk({tag, "_no_early_done"}, 64'(dn0), 64'(db));
    chk({tag, "_busy_mid"}, 64'(if0.busy), 1);
    tick(1);
    chk({tag, "_done_cyc"}, 64'(last0), 64'(e0 + 16));
    chk({tag, "_done_cnt"}, 64'(dn0), 64'(db + 1));
    chk({tag, "_freq0"}, 64'(if0.freq), 64'(exp0));
    chk({tag, "_freq1"}, 64'(if1.freq), 64'(exp1));
    tick(2);
    chk({tag, "_idle"}, 64'(if0.busy), 0);
  endtask

  initial begin
    int e0, db, ob;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(if0.busy), 0);
    chk("rst_done", 64'(if0.done), 0);
    chk("rst_freq", 64'(if0.freq), 0);
    chk("rst_ovr", 64'(if0.overrun), 0);
    chk("rst_freq1", 64'(if1.freq), 0);
    rst = 1'b0;
    tick(2);

    run_single("t1_single", fr(32'h0, 1, 32'h0100_0000, 1, 32'h0100_0000), 1, 1);
    run_single("t2_tie", fr(32'h0010_0000, 1, 32'h0300_FD00, 15, 32'h0300_FD00), 1, 1);
    run_single("t3_width", fr(32'h0, 3, 32'h7FFF_7FFF, 7, 32'h8000_8000), 7, 7);
    run_single("t4_dc", fr(32'h0, 0, 32'h4000_0000, 4, 32'h0020_0000), 4, 0);

    // Back-to-back with one dropped frame
    db = dn0; ob = ovr0;
    send(fr(32'h0, 2, 32'h0200_0000, 2, 32'h0200_0000), 1'b1);
    e0 = cyc; gap = 0;
    tick(4);
    send(fr(32'h0, 9, 32'h0200_0000, 9, 32'h0200_0000), 1'b1);
    tick(2);
    send(fr(32'h0, 12, 32'h0200_0000, 12, 32'h0200_0000), 1'b0);
    chk("t5_overrun_now", 64'(if0.overrun), 1);
    tick(8);
    chk("t5_done_a_cyc", 64'(last0), 64'(e0 + 16));
    chk("t5_freq_a", 64'(if0.freq), 2);
    tick(15);
    chk("t5_busy_gap", 64'(gap), 0);
    tick(1);
    chk("t5_done_b_cyc", 64'(last0), 64'(e0 + 32));
    chk("t5_freq_b", 64'(if0.freq), 9);
    tick(3);
    chk("t5_done_cnt", 64'(dn0), 64'(db + 2));
    chk("t5_ovr_cnt", 64'(ovr0), 64'(ob + 1));
    chk("t5_c_dropped", 64'(q0.size()), 0);

    // Frame arriving on the finishing edge with pending empty restarts immediately
    db = dn0; ob = ovr0;
    send(fr(32'h0, 3, 32'h0050_0050, 3, 32'h0050_0050), 1'b1);
    e0 = cyc;
    tick(15);
    send(fr(32'h0, 6, 32'h0050_0050, 6, 32'h0050_0050), 1'b1);
    chk("t7_done_a_cyc", 64'(last0), 64'(e0 + 16));
    tick(16);
    chk("t7_done_b_cyc", 64'(last0), 64'(e0 + 32));
    chk("t7_freq_b", 64'(if0.freq), 6);
    chk("t7_no_ovr", 64'(ovr0), 64'(ob));
    tick(2);

    // Frame arriving on the handover edge is taken into pending
    db = dn0; ob = ovr0;
    send(fr(32'h0, 5, 32'hFF00_0000, 5, 32'hFF00_0000), 1'b1);
    e0 = cyc;
    tick(2);
    send(fr(32'h0, 10, 32'h0000_0700, 10, 32'h0000_0700), 1'b1);
    tick(12);
    send(fr(32'h0, 14, 32'h0001_0001, 14, 32'h0001_0001), 1'b1);
    tick(32);
    chk("t8_done_cnt", 64'(dn0), 64'(db + 3));
    chk("t8_done_c_cyc", 64'(last0), 64'(e0 + 48));
    chk("t8_freq_c", 64'(if0.freq), 14);
    chk("t8_no_ovr", 64'(ovr0), 64'(ob));
    tick(2);

    // Reset mid-scan aborts the frame
    db = dn0;
    send(fr(32'h0, 11, 32'h0400_0000, 11, 32'h0400_0000), 1'b1);
    tick(6);
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", 64'(if0.busy), 0);
    chk("t6_rst_done", 64'(if0.done), 0);
    chk("t6_rst_freq", 64'(if0.freq), 0);
    chk("t6_rst_ovr", 64'(if0.overrun), 0);
    q0.delete();
    q1.delete();
    tick(1);
    rst = 1'b0;
    tick(2);
    send(fr(32'h0, 13, 32'h0000_8000, 13, 32'h0000_8000), 1'b1);
    e0 = cyc;
    tick(16);
    chk("t6_done_cyc", 64'(last0), 64'(e0 + 16));
    chk("t6_done_cnt", 64'(dn0), 64'(db + 1));
    chk("t6_freq", 64'(if0.freq), 13);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fft_peak_analyzer.md
Name: fft_peak_analyzer

Overview:
- Analysis stage directly downstream of the 16-point FFT in the FAS datapath.
- Captures each 16-bin FFT output frame when the FFT strobes it valid.
- Computes the squared magnitude of every bin, one bin per cycle, and reports the index of the strongest bin on freq with a one-cycle done pulse.
- Holds one pending frame so FFT frames arriving during a scan are not lost; reports overrun when a frame must be dropped.

Parameters:
- NBIN, 16, number of FFT bins per frame (fixed at 16; freq is 4 bits).
- DW, 16, width of each real/imag component (signed two's complement, 8.8 format).
- DC_EXCLUDE, 1, 1 = bin 0 is never a peak candidate; 0 = bin 0 competes normally.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- fft_valid  in  1  one-cycle strobe: fft_data holds a complete frame.
- fft_data  in  512  packed frame; bin k at [32k+31:32k] = {real[15:0], imag[15:0]}, k = 0..15 (bin 0 = fft_d0).
- busy  out  1  a scan is in progress.
- done  out  1  one-cycle pulse: freq is updated for the completed frame.
- freq  out  4  index of the max-magnitude bin of the last completed frame; holds until the next done.
- overrun  out  1  one-cycle pulse: an incoming frame was dropped.

Behaviour:
- Reset (async, rst=1): busy=0, done=0, freq=0, overrun=0, bin counter=0, pending_valid=0, max register=0. A reset asserted mid-scan aborts the scan; no done is produced for that frame.
- States:
  - IDLE: when fft_valid=1, latch fft_data into the active buffer, set cnt=0, go to SCAN; busy=1 from the next cycle.
  - SCAN: each cycle process bin cnt, then cnt increments.
  - After bin 15 is processed: if pending_valid, move the pending buffer to active, clear pending_valid, cnt=0, stay in SCAN with no idle cycle. Otherwise go to IDLE and set busy=0.
- Magnitude: mag = re*re + im*im, with re and im signed 16-bit. Each product is computed as 32-bit signed and the sum as 32-bit unsigned. The maximum value is 2^31 for {8000,8000}, so there is no overflow; the unsigned compare is mandatory.
- Peak tracking:
  - The first candidate bin of a frame loads max/idx unconditionally. This is bin 1 when DC_EXCLUDE=1, bin 0 otherwise.
  - Later bins replace max/idx only when mag > max (strictly greater), so ties keep the lower index.
  - When DC_EXCLUDE=1, bin 0 still consumes its cycle but is ignored.
- Output timing:
  - If fft_valid is sampled at edge E0, bin k is processed at edge E(k+1).
  - At E16, freq is registered with the final index (including the bin-15 comparison) and done is set to 1.
  - done is high for exactly the cycle after E16. Latency from capture edge to done visible is 16 cycles.
- Back-to-back frames: back-to-back done pulses are exactly 16 cycles apart when a frame is pending.
- fft_valid while busy:
  - If pending_valid=0, latch into the pending buffer and set pending_valid=1.
  - If pending_valid=1, drop the new frame (pending is kept unchanged) and pulse overrun for one cycle.
  - fft_valid on the same edge that pending moves to active is accepted into pending (no overrun).
  - fft_valid on the edge that finishes a scan with pending empty starts the new scan immediately (IDLE is bypassed).
- Inputs with X are not checked; freq is never X after reset.

Test Plan:
1. Single peak: bin 1 = {0100,0000}, all other bins 0, fft_valid at cycle 0 -> done=1 at cycle 16, freq=1; busy high cycles 1-16.
2. Symmetric tie: bin 1 = bin 15 = {0300,FD00}, others {0010,0000} -> freq=1 (lower index wins); no intermediate done.
3. Width/sign check: bin 3 = {7FFF,7FFF} (mag 2147352578), bin 7 = {8000,8000} (mag 2147483648) -> freq=7.
4. DC handling: bin 0 = {4000,0000}, bin 4 = {0020,0000}, rest 0 -> DC_EXCLUDE=1 gives freq=4; DC_EXCLUDE=0 gives freq=0.
5. Back-to-back frames: frame A (peak bin 2) at cycle 0, B (peak bin 9) at cycle 5, C (peak bin 12) at cycle 8:
   - done at cycle 16 with freq=2, and at cycle 32 with freq=9.
   - overrun pulse at cycle 9; C is never reported.
   - busy stays 1 through cycle 32.
6. Reset mid-scan: frame at cycle 0, rst pulsed at cycle 7 -> all outputs 0 immediately; no done at cycle 16. A new frame at cycle 10 gives done at cycle 26 with the correct freq.
